mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mult_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Two-requester round-robin arbiter in front of a 4x4 shift-and-add multiplier.
// Optional macro MULT_ARBITER_BCD_EN registers a BCD copy of the product on z_bcd.
module mult_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [3:0]  a0,
    input  logic [3:0]  b0,
    input  logic        req1,
    input  logic [3:0]  a1,
    input  logic [3:0]  b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic [7:0]  z,
    output logic [11:0] z_bcd
);

    localparam int unsigned OP_W   = 4;
    localparam int unsigned PROD_W = 8;
    localparam int unsigned CNT_W  = 2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CALC = 1'b1;

    logic [0:0]        r_state, w_state;
    logic              r_last, w_last;
    logic              r_win, w_win;
    logic [OP_W-1:0]   r_a, w_a;
    logic [OP_W-1:0]   r_b, w_b;
    logic [PROD_W-1:0] r_acc, w_acc;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic              r_gnt0, w_gnt0;
    logic              r_gnt1, w_gnt1;
    logic              r_done, w_done;
    logic              r_done_id, w_done_id;
    logic [PROD_W-1:0] r_z, w_z;

    logic              w_pick;
    logic [PROD_W-1:0] w_add;
    logic [PROD_W-1:0] w_sum;

    // Under contention the requester not served last wins.
    assign w_pick = (req0 & req1) ? ~r_last : req1;
    assign w_add  = r_b[r_cnt] ? (PROD_W'(r_a) << r_cnt) : '0;
    assign w_sum  = r_acc + w_add;

    always_comb begin
        w_state   = r_state;
        w_last    = r_last;
        w_win     = r_win;
        w_a       = r_a;
        w_b       = r_b;
        w_acc     = r_acc;
        w_cnt     = r_cnt;
        w_gnt0    = 1'b0;
        w_gnt1    = 1'b0;
        w_done    = 1'b0;
        w_done_id = r_done_id;
        w_z       = r_z;
        case (r_state)
            IDLE: begin
                if (req0 | req1) begin
                    w_state = CALC;
                    w_win   = w_pick;
                    w_last  = w_pick;
                    w_a     = w_pick ? a1 : a0;
                    w_b     = w_pick ? b1 : b0;
                    w_acc   = '0;
                    w_cnt   = '0;
                    w_gnt0  = ~w_pick;
                    w_gnt1  = w_pick;
                end
            end
            CALC: begin
                w_acc = w_sum;
                if (r_cnt == CNT_W'(3)) begin
                    w_state   = IDLE;
                    w_z       = w_sum;
                    w_done    = 1'b1;
                    w_done_id = r_win;
                    w_cnt     = '0;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_win     <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_z       <= '0;
        end else begin
            r_state   <= w_state;
            r_last    <= w_last;
            r_win     <= w_win;
            r_a       <= w_a;
            r_b       <= w_b;
            r_acc     <= w_acc;
            r_cnt     <= w_cnt;
            r_gnt0    <= w_gnt0;
            r_gnt1    <= w_gnt1;
            r_done    <= w_done;
            r_done_id <= w_done_id;
            r_z       <= w_z;
        end
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign busy    = (r_state == CALC);
    assign done    = r_done;
    assign done_id = r_done_id;
    assign z       = r_z;

`ifdef MULT_ARBITER_BCD_EN
    localparam int unsigned BCD_W = 12;

    logic [BCD_W-1:0] r_z_bcd;

    // Double-dabble: add 3 to any digit >= 5 before each shift.
    function automatic logic [BCD_W-1:0] bin2bcd(input logic [PROD_W-1:0] bin);
        logic [BCD_W+PROD_W-1:0] sh;
        sh = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
            if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
            if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
            sh = sh << 1;
        end
        return sh[19:8];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_z_bcd <= '0;
        end else if (w_done) begin
            r_z_bcd <= bin2bcd(w_sum);
        end
    end

    assign z_bcd = r_z_bcd;
`else
    assign z_bcd = 12'h000;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed table, corner sequences and
// randomized transactions against a transaction-level round-robin/product model.
module tb_mult_arbiter;

    logic        clk;
    logic        reset;
    logic        req0;
    logic [3:0]  a0;
    logic [3:0]  b0;
    logic        req1;
    logic [3:0]  a1;
    logic [3:0]  b1;
    logic        gnt0;
    logic        gnt1;
    logic        busy;
    logic        done;
    logic        done_id;
    logic [7:0]  z;
    logic [11:0] z_bcd;

    int checks = 0;
    int errors = 0;
    int last_served = 1;

    mult_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .a0      (a0),
        .b0      (b0),
        .req1    (req1),
        .a1      (a1),
        .b1      (b1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .z       (z),
        .z_bcd   (z_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit r0; int x0; int y0;
        bit r1; int x1; int y1;
        int exp_w; int exp_z;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_bcd(input int v);
`ifdef MULT_ARBITER_BCD_EN
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
`else
        return 0 * v;
`endif
    endfunction

    function automatic int rr_pick(input bit r0, input bit r1);
        if (r0 && r1) return (last_served == 1) ? 0 : 1;
        return r1 ? 1 : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full job: drive requests, expect grant next edge, 4 busy cycles, then done.
    task automatic txn(input bit r0, input int x0, input int y0,
                       input bit r1, input int x1, input int y1,
                       input int w, input int pz);
        req0 = r0; a0 = 4'(x0); b0 = 4'(y0);
        req1 = r1; a1 = 4'(x1); b1 = 4'(y1);
        step();
        chk("gnt0", 32'(gnt0), 32'(w == 0));
        chk("gnt1", 32'(gnt1), 32'(w == 1));
        chk("busy_grant", 32'(busy), 1);
        chk("done_grant", 32'(done), 0);
        last_served = w;
        if (w == 0) req0 = 1'b0; else req1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (w == 0) begin a0 = 4'($urandom); b0 = 4'($urandom); end
            else        begin a1 = 4'($urandom); b1 = 4'($urandom); end
            step();
            if (k < 3) begin
                chk("busy_calc", 32'(busy), 1);
                chk("gnt_calc", 32'({gnt0, gnt1}), 0);
                chk("done_calc", 32'(done), 0);
            end
        end
        chk("done", 32'(done), 1);
        chk("done_id", 32'(done_id), 32'(w));
        chk("z", 32'(z), 32'(pz));
        chk("z_bcd", 32'(z_bcd), 32'(exp_bcd(pz)));
        chk("busy_end", 32'(busy), 0);
        chk("gnt_end", 32'({gnt0, gnt1}), 0);
    endtask

    initial begin
        vec_t tbl[12];
        bit p0, p1;
        int o0x, o0y, o1x, o1y, w;

        tbl[0]  = '{1, 4, 5,    0, 0, 0,    0, 20};
        tbl[1]  = '{0, 0, 0,    1, 15, 15,  1, 225};
        tbl[2]  = '{1, 3, 1,    1, 2, 10,   0, 3};
        tbl[3]  = '{1, 7, 9,    1, 2, 10,   1, 20};
        tbl[4]  = '{1, 7, 9,    0, 0, 0,    0, 63};
        tbl[5]  = '{1, 0, 0,    0, 0, 0,    0, 0};
        tbl[6]  = '{1, 15, 1,   1, 6, 6,    1, 36};
        tbl[7]  = '{1, 15, 1,   0, 0, 0,    0, 15};
        tbl[8]  = '{0, 0, 0,    1, 10, 10,  1, 100};
        tbl[9]  = '{0, 0, 0,    1, 9, 11,   1, 99};
        tbl[10] = '{1, 12, 12,  1, 13, 14,  0, 144};
        tbl[11] = '{0, 0, 0,    1, 13, 14,  1, 182};

        reset = 1'b0;
        req0 = 1'b0; a0 = '0; b0 = '0;
        req1 = 1'b0; a1 = '0; b1 = '0;
        step();
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gnt", 32'({gnt0, gnt1}), 0);
        chk("rst_done", 32'({done, done_id}), 0);
        chk("rst_z", 32'(z), 0);
        chk("rst_z_bcd", 32'(z_bcd), 0);
        reset = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 0);

        for (int i = 0; i < 12; i++)
            txn(tbl[i].r0, tbl[i].x0, tbl[i].y0, tbl[i].r1, tbl[i].x1, tbl[i].y1,
                tbl[i].exp_w, tbl[i].exp_z);

        // Zero product; req1 raised while busy waits for the cycle after IDLE.
        req0 = 1'b1; a0 = 4'd0; b0 = 4'd0;
        step();
        chk("z0_gnt0", 32'(gnt0), 1);
        req0 = 1'b0;
        req1 = 1'b1; a1 = 4'd5; b1 = 4'd3;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("busy_req1_held", 32'(gnt1), 0);
        end
        step();
        chk("z0_done", 32'(done), 1);
        chk("z0_z", 32'(z), 0);
        chk("z0_gnt1_not_yet", 32'(gnt1), 0);
        step();
        chk("z0_done_once", 32'(done), 0);
        chk("late_gnt1", 32'(gnt1), 1);
        req1 = 1'b0;
        repeat (4) step();
        chk("late_done", 32'(done), 1);
        chk("late_z", 32'(z), 15);
        chk("late_id", 32'(done_id), 1);
        last_served = 1;

        // Operand change after capture must not alter the product.
        req0 = 1'b1; a0 = 4'd14; b0 = 4'd1;
        step();
        chk("hold_gnt0", 32'(gnt0), 1);
        req0 = 1'b0; a0 = 4'd2;
        repeat (4) step();
        chk("hold_z", 32'(z), 14);
        chk("hold_z_bcd", 32'(z_bcd), 32'(exp_bcd(14)));
        last_served = 0;

        // Reset in 2nd CALC cycle aborts the job and reloads the pointer.
        req0 = 1'b1; a0 = 4'd3; b0 = 4'd3;
        step();
        chk("abort_gnt0", 32'(gnt0), 1);
        req0 = 1'b0;
        step();
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_z", 32'(z), 0);
        chk("abort_z_bcd", 32'(z_bcd), 0);
        chk("abort_done", 32'(done), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("abort_no_done", 32'(done), 0);
        end
        last_served = 1;
        txn(1, 2, 3, 1, 4, 4, 0, 6);

        // Randomized traffic; a losing requester keeps holding its request.
        p0 = 1'b0; p1 = 1'b1; o1x = 4; o1y = 4; o0x = 0; o0y = 0;
        for (int n = 0; n < 300; n++) begin
            if (!p0 && ($urandom % 2 == 1)) begin
                p0 = 1'b1; o0x = int'($urandom % 16); o0y = int'($urandom % 16);
            end
            if (!p1 && ($urandom % 2 == 1)) begin
                p1 = 1'b1; o1x = int'($urandom % 16); o1y = int'($urandom % 16);
            end
            if (!p0 && !p1) begin
                req0 = 1'b0; req1 = 1'b0;
                step();
                chk("rnd_idle_gnt", 32'({gnt0, gnt1}), 0);
                chk("rnd_idle_busy", 32'(busy), 0);
                chk("rnd_idle_done", 32'(done), 0);
            end else begin
                w = rr_pick(p0, p1);
                txn(p0, o0x, o0y, p1, o1x, o1y, w, (w == 0) ? o0x * o0y : o1x * o1y);
                if (w == 0) p0 = 1'b0; else p1 = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
